// File: rtl/prog_mem_loader.sv
// Byte-streaming program memory loader with a big-endian word fetch port.
// Load: one byte per cycle when ready. Fetch: 1-cycle latency. Fetches are dropped while a load is busy.
module prog_mem_loader #(
  parameter int ADDR_W          = 32,
  parameter int DEPTH_BYTES     = 1024,
  parameter int WORD_BYTES      = 4,
  parameter int ALLOW_UNALIGNED = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load_start,
  input  logic [ADDR_W-1:0]               load_base,
  input  logic                            load_valid,
  input  logic [7:0]                      load_byte,
  input  logic                            load_last,
  output logic                            load_ready,
  output logic                            load_busy,
  output logic                            load_done,
  output logic [$clog2(DEPTH_BYTES):0]    load_count,
  output logic                            load_err,
  input  logic                            fetch_en,
  input  logic [ADDR_W-1:0]               fetch_addr,
  output logic [8*WORD_BYTES-1:0]         fetch_data,
  output logic                            fetch_valid,
  output logic                            fetch_fault
);

  localparam int IDX_W = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t state, nextState;

  logic [7:0]              mem [DEPTH_BYTES];
  logic [ADDR_W-1:0]       ptr;
  logic                    accept;
  logic                    ptrInRange;
  logic                    fetchOk;
  logic                    rangeFault;
  logic                    alignFault;
  logic [IDX_W-1:0]        fetchIdx;
  logic [8*WORD_BYTES-1:0] fetchWord;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (load_start) nextState = LOAD;
      LOAD:    if (accept && load_last) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state == LOAD);
    load_busy  = (state == LOAD);
    load_done  = (state == DONE);
  end

  assign accept     = load_valid && load_ready;
  assign ptrInRange = {1'b0, ptr} < DEPTH_EXT;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      load_count <= '0;
      load_err   <= 1'b0;
    end else if (state == IDLE && load_start) begin
      ptr        <= load_base;
      load_count <= '0;
      load_err   <= {1'b0, load_base} >= DEPTH_EXT;
    end else if (accept) begin
      // Pointer keeps advancing past the end so a long overrun stays flagged.
      if (ptr != '1) ptr <= ptr + ADDR_W'(1);
      if (ptrInRange) load_count <= load_count + 1'b1;
      else            load_err   <= 1'b1;
    end
  end

  // Storage is deliberately not reset; a reset mid-session keeps written bytes.
  always_ff @(posedge clk) begin
    if (!rst && accept && ptrInRange) mem[ptr[IDX_W-1:0]] <= load_byte;
  end

  assign fetchOk    = fetch_en && (state == IDLE);
  assign rangeFault = ({1'b0, fetch_addr} + (ADDR_W+1)'(WORD_BYTES - 1)) >= DEPTH_EXT;
  assign alignFault = (ALLOW_UNALIGNED == 0) && ((fetch_addr % ADDR_W'(WORD_BYTES)) != '0);
  assign fetchIdx   = fetch_addr[IDX_W-1:0];

  // Lowest address lands in the MSBs; no index wrap since out-of-range faults.
  always_comb begin
    fetchWord = '0;
    for (int i = 0; i < WORD_BYTES; i++)
      fetchWord[8*(WORD_BYTES-1-i) +: 8] = mem[fetchIdx + IDX_W'(i)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_data  <= '0;
    end else begin
      fetch_valid <= fetchOk;
      fetch_fault <= fetchOk && (rangeFault || alignFault);
      fetch_data  <= (fetchOk && !rangeFault && !alignFault) ? fetchWord : '0;
    end
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench: aligned-only and unaligned-capable instances share all inputs.
module tb_prog_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start, load_valid, load_last, fetch_en;
  logic [31:0] load_base, fetch_addr;
  logic [7:0]  load_byte;

  logic        aReady, aBusy, aDone, aErr, aValid, aFault;
  logic [10:0] aCount;
  logic [31:0] aData;
  logic        uReady, uBusy, uDone, uErr, uValid, uFault;
  logic [10:0] uCount;
  logic [31:0] uData;

  int nVec = 0;
  int nMis = 0;

  always #5 clk = ~clk;

  prog_mem_loader #(.ALLOW_UNALIGNED(0)) dutA (
    .clk(clk), .rst(rst), .load_start(load_start), .load_base(load_base),
    .load_valid(load_valid), .load_byte(load_byte), .load_last(load_last),
    .load_ready(aReady), .load_busy(aBusy), .load_done(aDone),
    .load_count(aCount), .load_err(aErr), .fetch_en(fetch_en),
    .fetch_addr(fetch_addr), .fetch_data(aData), .fetch_valid(aValid),
    .fetch_fault(aFault));

  prog_mem_loader #(.ALLOW_UNALIGNED(1)) dutU (
    .clk(clk), .rst(rst), .load_start(load_start), .load_base(load_base),
    .load_valid(load_valid), .load_byte(load_byte), .load_last(load_last),
    .load_ready(uReady), .load_busy(uBusy), .load_done(uDone),
    .load_count(uCount), .load_err(uErr), .fetch_en(fetch_en),
    .fetch_addr(fetch_addr), .fetch_data(uData), .fetch_valid(uValid),
    .fetch_fault(uFault));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startLoad(input logic [31:0] base);
    load_start = 1'b1;
    load_base  = base;
    tick();
    load_start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic last);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic doFetch(input logic [31:0] a);
    fetch_en   = 1'b1;
    fetch_addr = a;
    tick();
    fetch_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_start = 0; load_base = 0; load_valid = 0; load_byte = 0;
    load_last = 0; fetch_en = 0; fetch_addr = 0;
    tick(); tick();
    check("rst_ready", aReady, 0);
    check("rst_busy", aBusy, 0);
    check("rst_done", aDone, 0);
    check("rst_count", aCount, 0);
    check("rst_err", aErr, 0);
    check("rst_fvalid", aValid, 0);
    check("rst_ffault", aFault, 0);
    check("rst_fdata", aData, 0);
    rst = 1'b0;
    tick();

    // Basic 8-byte load at 0x10
    startLoad(32'h10);
    check("t1_busy", aBusy, 1);
    check("t1_ready", aReady, 1);
    for (int i = 0; i < 8; i++) sendByte(8'(8'h11 * (i + 1)), i == 7);
    check("t1_done", aDone, 1);
    check("t1_busy_off", aBusy, 0);
    check("t1_count", aCount, 8);
    check("t1_err", aErr, 0);
    tick();
    check("t1_done_pulse", aDone, 0);
    doFetch(32'h10);
    check("f10_valid", aValid, 1);
    check("f10_data", aData, 32'h11223344);
    check("f10_fault", aFault, 0);
    doFetch(32'h14);
    check("f14_data", aData, 32'h55667788);
    doFetch(32'h11);
    check("f11_a_valid", aValid, 1);
    check("f11_a_fault", aFault, 1);
    check("f11_a_data", aData, 0);
    check("f11_u_fault", uFault, 0);
    check("f11_u_data", uData, 32'h22334455);
    tick();
    check("idle_fvalid", aValid, 0);

    // Overrun at the top of memory
    startLoad(32'd1022);
    for (int i = 0; i < 4; i++) sendByte(8'(8'hA1 + i), i == 3);
    check("t2_count", aCount, 2);
    check("t2_err", aErr, 1);
    tick();
    check("t2_err_sticky", aErr, 1);
    doFetch(32'h3FC);
    check("f3fc_valid", aValid, 1);
    check("f3fc_fault", aFault, 0);
    check("f3fc_low", aData[15:0], 16'hA1A2);
    doFetch(32'h3FD);
    check("f3fd_u_fault", uFault, 1);
    check("f3fd_u_data", uData, 0);
    doFetch(32'hFFFFFFFC);
    check("fhigh_a_fault", aFault, 1);
    check("fhigh_u_fault", uFault, 1);
    startLoad(32'h400);
    check("t2_base_oob_err", aErr, 1);
    sendByte(8'h5A, 1'b1);
    check("t2_oob_count", aCount, 0);
    tick();
    startLoad(32'h100);
    check("t2_err_cleared", aErr, 0);
    sendByte(8'h77, 1'b1);
    tick();

    // Gappy stream with fetch held high during the session
    fetch_en = 1'b1; fetch_addr = 32'h20;
    startLoad(32'h20);
    for (int i = 0; i < 4; i++) begin
      sendByte(8'(8'hC0 + i), i == 3);
      check("t3_fvalid_on", aValid, 0);
      if (i != 3) begin
        tick();
        check("t3_fvalid_gap", aValid, 0);
      end
    end
    check("t3_done", aDone, 1);
    check("t3_count", aCount, 4);
    tick();
    check("t3_fvalid_done", aValid, 0);
    tick();
    check("t3_fvalid_back", aValid, 1);
    check("t3_data", aData, 32'hC0C1C2C3);
    tick();
    check("t3_fvalid_b2b", aValid, 1);
    fetch_en = 1'b0;
    tick();

    // Reset partway through a session
    startLoad(32'h10);
    for (int i = 0; i < 3; i++) sendByte(8'(8'hE0 + i), 1'b0);
    check("t4_count3", aCount, 3);
    load_valid = 1'b1; load_byte = 8'hE3; rst = 1'b1;
    tick();
    check("t4_rst_busy", aBusy, 0);
    check("t4_rst_ready", aReady, 0);
    check("t4_rst_count", aCount, 0);
    check("t4_rst_err", aErr, 0);
    check("t4_rst_done", aDone, 0);
    rst = 1'b0; load_valid = 1'b0;
    tick();
    doFetch(32'h10);
    check("t4_f10", aData, 32'hE0E1E244);
    doFetch(32'h14);
    check("t4_f14", aData, 32'h55667788);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
